// File: rtl/game2048_pkg.sv
// Shared constants and types for the 2048 board datapath.
package game2048_pkg;

    localparam int CELLS  = 16;
    localparam int CELL_W = 4;
    localparam int POS_W  = 4;

    // Tile exponents: 0 marks an empty cell, 1 is a "2" tile, 2 is a "4" tile.
    localparam logic [CELL_W-1:0] EXP_EMPTY = 4'd0;
    localparam logic [CELL_W-1:0] EXP_TWO   = 4'd1;
    localparam logic [CELL_W-1:0] EXP_FOUR  = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_TRY,
        ST_SCAN,
        ST_WRITE,
        ST_FULL
    } placer_state_e;

endpackage

// File: rtl/empty_mask_encoder.sv
// Combinational board-to-occupancy encoder: bit i is set when cell i holds
// the empty exponent. Also used by the move logic for game-over detection.
module empty_mask_encoder
    import game2048_pkg::*;
#(
    parameter int N_CELLS = CELLS,
    parameter int C_W     = CELL_W
) (
    input  logic [N_CELLS*C_W-1:0] board_i,
    output logic [N_CELLS-1:0]     mask_o
);

    genvar gi;
    generate
        for (gi = 0; gi < N_CELLS; gi++) begin : g_cell
            // One comparator per cell against the empty exponent.
            assign mask_o[gi] = (board_i[gi*C_W +: C_W] == C_W'(EXP_EMPTY));
        end
    endgenerate

endmodule

// File: rtl/new_block_placer.sv
// Places one new tile after every move: snapshots the board, samples random
// positions until one hits an empty cell (falling back to a linear scan after
// MAX_TRIES misses) and issues a single write, or reports a full board.
module new_block_placer
    import game2048_pkg::*;
#(
    parameter int MAX_TRIES = 8
) (
    input  logic                    clk,
    input  logic                    rst,        // active-low, asynchronous
    input  logic                    start,
    input  logic [CELLS*CELL_W-1:0] board_in,
    input  logic [POS_W-1:0]        rand_pos,
    input  logic [CELL_W-1:0]       rand_exp,
    output logic [CELLS-1:0]        empty_mask,
    output logic                    wr_en,
    output logic [POS_W-1:0]        wr_addr,
    output logic [CELL_W-1:0]       wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    board_full
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    placer_state_e             state_q;
    logic [CELLS*CELL_W-1:0]   board_q;
    logic [CELLS-1:0]          empty_mask_q;
    logic [TRY_W-1:0]          tries_q;
    logic [POS_W-1:0]          scan_idx_q;
    logic [POS_W-1:0]          wr_addr_q;
    logic [CELL_W-1:0]         wr_data_q;
    logic                      wr_en_q;
    logic                      done_q;
    logic                      full_q;

    logic [CELLS-1:0]          mask_d;
    logic [CELL_W-1:0]         exp_d;

    empty_mask_encoder #(
        .N_CELLS (CELLS),
        .C_W     (CELL_W)
    ) u_encoder (
        .board_i (board_q),
        .mask_o  (mask_d)
    );

    // Only "2" and "4" tiles may spawn; anything else from the generator becomes a "2".
    always_comb begin
        exp_d = EXP_TWO;
        if (rand_exp == EXP_TWO || rand_exp == EXP_FOUR) begin
            exp_d = rand_exp;
        end
    end

    // Placement FSM with registered strobes. The write/done strobes are set on
    // the edge leaving WRITE/FULL, so a start seen while done is still high is
    // the tail of the same request and is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            board_q      <= '0;
            empty_mask_q <= '0;
            tries_q      <= '0;
            scan_idx_q   <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            done_q       <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !done_q) begin
                        board_q <= board_in;
                        state_q <= ST_SNAP;
                    end
                end
                ST_SNAP: begin
                    empty_mask_q <= mask_d;
                    if (mask_d == '0) begin
                        state_q <= ST_FULL;
                    end else begin
                        tries_q <= '0;
                        state_q <= ST_TRY;
                    end
                end
                ST_TRY: begin
                    if (empty_mask_q[rand_pos]) begin
                        wr_addr_q <= rand_pos;
                        wr_data_q <= exp_d;
                        state_q   <= ST_WRITE;
                    end else if (tries_q == LAST_TRY) begin
                        scan_idx_q <= rand_pos + POS_W'(1);
                        state_q    <= ST_SCAN;
                    end else begin
                        tries_q <= tries_q + TRY_W'(1);
                    end
                end
                ST_SCAN: begin
                    // Mask is known nonzero here, so this ends within CELLS cycles.
                    if (empty_mask_q[scan_idx_q]) begin
                        wr_addr_q <= scan_idx_q;
                        wr_data_q <= exp_d;
                        state_q   <= ST_WRITE;
                    end else begin
                        scan_idx_q <= scan_idx_q + POS_W'(1);
                    end
                end
                ST_WRITE: begin
                    wr_en_q <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                ST_FULL: begin
                    full_q  <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign empty_mask = empty_mask_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign board_full = full_q;

endmodule

// File: tb/tb_new_block_placer.sv
// Scoreboard bench for new_block_placer: each request pushes its expected
// outcome; the monitor pops and compares on every done pulse.
module tb_new_block_placer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] board_in = '0;
    logic [3:0]  rand_pos = '0;
    logic [3:0]  rand_exp = '0;
    logic [15:0] empty_mask;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        busy;
    logic        done;
    logic        board_full;

    typedef struct {
        bit          full;
        logic [3:0]  addr;
        logic [3:0]  data;
        logic [15:0] mask;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    new_block_placer #(.MAX_TRIES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .board_in   (board_in),
        .rand_pos   (rand_pos),
        .rand_exp   (rand_exp),
        .empty_mask (empty_mask),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .board_full (board_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Board with every cell holding a "2" except empty_idx (-1 gives a full board).
    function automatic logic [63:0] make_board(input int empty_idx);
        logic [63:0] b;
        for (int i = 0; i < 16; i++) begin
            b[i*4 +: 4] = (i == empty_idx) ? 4'd0 : 4'd1;
        end
        return b;
    endfunction

    task automatic issue(input logic [63:0] b, input logic [3:0] pos, input logic [3:0] ex,
                         input bit full, input logic [3:0] addr, input logic [3:0] data,
                         input logic [15:0] mask, input int lat);
        exp_t e;
        @(negedge clk);
        board_in = b;
        rand_pos = pos;
        rand_exp = ex;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.full = full; e.addr = addr; e.data = data; e.mask = mask; e.lat = lat;
        e.start_cyc = cyc;
        sb.push_back(e);
        $display("REQ pos=%0d exp=%0d board=%016h expect full=%0b addr=%0d data=%0d lat=%0d",
                 pos, ex, b, full, addr, data, lat);
        check_eq("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        check_eq("req_timeout", sb.size() == 0, 1);
        repeat (2) @(posedge clk);
    endtask

    // Monitor: compare each done pulse against the oldest expected outcome.
    always @(negedge clk) begin
        if (rst) begin
            if (done || wr_en) check_eq("wr_en_vs_done", wr_en, done && !board_full);
            if (done) begin
                exp_t e;
                done_cnt++;
                check_eq("done_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    $display("DONE full=%0b wr_en=%0b addr=%0d data=%0d mask=%04h lat=%0d",
                             board_full, wr_en, wr_addr, wr_data, empty_mask, cyc - e.start_cyc);
                    check_eq("board_full", board_full, e.full);
                    check_eq("latency", cyc - e.start_cyc, e.lat);
                    check_eq("empty_mask", empty_mask, e.mask);
                    if (!e.full) begin
                        check_eq("wr_addr", wr_addr, e.addr);
                        check_eq("wr_data", wr_data, e.data);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", {empty_mask, wr_en, wr_addr, wr_data, busy, done, board_full}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Empty board, direct hit
        issue('0, 4'd5, 4'd1, 0, 4'd5, 4'd1, 16'hFFFF, 3);
        wait_idle();
        check_eq("wr_addr_hold", wr_addr, 5);

        // Only cell 9 empty, position stuck at 3: eight misses, scan 4..9
        issue(make_board(9), 4'd3, 4'd2, 0, 4'd9, 4'd2, 16'h0200, 16);
        wait_idle();

        // Only cell 0 empty, position stuck at 15: scan wraps to 0 immediately
        issue(make_board(0), 4'd15, 4'd1, 0, 4'd0, 4'd1, 16'h0001, 11);
        wait_idle();

        // Full board
        issue(make_board(-1), 4'd4, 4'd1, 1, 4'd0, 4'd0, 16'h0000, 2);
        wait_idle();
        check_eq("wr_addr_after_full", wr_addr, 0);

        // Bad exponent sanitised; second start while busy and a board change
        // after the snapshot are both ignored
        issue('0, 4'd2, 4'd7, 0, 4'd2, 4'd1, 16'hFFFF, 3);
        @(negedge clk);
        start    = 1'b1;
        board_in = make_board(-1);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);
        check_eq("single_done", done_cnt, 5);

        // Asynchronous reset while scanning aborts the request
        issue(make_board(9), 4'd3, 4'd2, 0, 4'd9, 4'd2, 16'h0200, 16);
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_reset_outputs",
                 {empty_mask, wr_en, wr_addr, wr_data, busy, done, board_full}, 0);
        sb.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        check_eq("no_done_after_abort", done_cnt, 5);

        // Fresh request after reset completes normally
        issue('0, 4'd7, 4'd2, 0, 4'd7, 4'd2, 16'hFFFF, 3);
        wait_idle();
        check_eq("total_dones", done_cnt, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
